// File: rtl/seq_det_pkg.sv
// seq_det_pkg: FSM state encoding shared by the serial pattern detector
package seq_det_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {S_FILL = 2'd0, S_HUNT = 2'd1} state_t;
endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist: bit history + saturating fill count; in shift flush serin, out window (held bits + serin) ready (fill>=PAT_W-1) arm (this shift fills)
module seq_det_hist #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             flush,
  input  logic             serin,
  output logic [PAT_W-1:0] window,
  output logic             ready,
  output logic             arm
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  assign window = {hist, serin};
  assign ready  = fill >= FW'(PAT_W - 1);
  assign arm    = shift && fill == FW'(PAT_W - 2);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= window[PAT_W-2:0];
      fill <= (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    end
  end
endmodule

// File: rtl/param_overlap_seq_det.sv
// param_overlap_seq_det: run-time programmable serial pattern detector; in serin in_valid cfg_load cfg_pattern cfg_overlap cnt_clr [cfg_mask with SEQ_DET_MASK_EN], out det_out match_cnt state
module param_overlap_seq_det
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 4'b1011,
  parameter bit               DEF_OVERLAP = 1'b1,
  parameter int               CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serin,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0]   cfg_mask,
`endif
  input  logic               cnt_clr,
  output logic               det_out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [STATE_W-1:0] state
);
  state_t           state_q, state_nxt;
  logic [PAT_W-1:0] pattern, mask, window;
  logic             overlap, shift, flush, ready, arm, match;
  assign shift = in_valid && !cfg_load;
  assign match = shift && ready && state_q == S_HUNT && ((window ^ pattern) & mask) == '0;
  assign state = state_q;
  seq_det_hist #(.PAT_W(PAT_W)) u_hist (
    .clk(clk), .rst(rst), .shift(shift), .flush(flush), .serin(serin),
    .window(window), .ready(ready), .arm(arm)
  );
  always_comb begin
    state_nxt = S_FILL;
    flush     = 1'b1;
    if (!cfg_load)
      case (state_q)
        S_FILL: begin
          state_nxt = arm ? S_HUNT : S_FILL;
          flush     = 1'b0;
        end
        S_HUNT: begin
          state_nxt = (match && !overlap) ? S_FILL : S_HUNT;
          flush     = match && !overlap;
        end
        default: ;
      endcase
  end
`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk)
    if (rst) mask <= '1;
    else if (cfg_load) mask <= cfg_mask;
`else
  assign mask = '1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      pattern   <= DEF_PATTERN;
      overlap   <= DEF_OVERLAP;
      det_out   <= 1'b0;
      match_cnt <= '0;
    end else begin
      state_q   <= state_nxt;
      det_out   <= match;
      pattern   <= cfg_load ? cfg_pattern : pattern;
      overlap   <= cfg_load ? cfg_overlap : overlap;
      match_cnt <= cnt_clr ? '0 : (match && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
    end
  end
endmodule
